bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Parallel-to-serial front end for the serial pattern-detector chain.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clk on ser_out.
- ser_out connects directly to the detector's serial `in`. ser_valid marks cycles that carry real data bits.
- Supports back-to-back streaming, so patterns spanning word boundaries reach the detector unbroken.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first, 0 = bit 0 first.
- GAP_CYCLES, 0, number of forced idle cycles inserted after each word; legal range 0..15.
- IDLE_LEVEL, 0, value driven on ser_out whenever ser_valid=0.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- s_data  input  WIDTH  parallel word, sampled only on handshake.
- s_valid  input  1  upstream word available.
- s_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  registered serial bit to the detector.
- ser_valid  output  1  ser_out carries a data bit.
- word_done  output  1  one-cycle pulse, high during the last bit of each word.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- While reset=1:
  - state=IDLE; shift register and counters cleared.
  - ser_out=IDLE_LEVEL; ser_valid=0, word_done=0, busy=0, s_ready=0.
- Handshake: a word transfers on a rising edge where s_valid=1 and s_ready=1. s_data is captured into the shift register at that edge only; later changes to s_data are ignored.
- s_ready is combinational and low while reset=1. Otherwise it is high when either:
  - state=IDLE, or
  - state=SHIFT, the current bit is the last, and GAP_CYCLES=0 (streaming).
- State machine, three states:
  - IDLE: ser_valid=0, ser_out=IDLE_LEVEL. On handshake go to SHIFT with bit_cnt=0.
  - SHIFT: one bit per cycle; ser_valid=1; bit_cnt runs 0..WIDTH-1. When bit_cnt=WIDTH-1, word_done=1 and the next state is:
    - SHIFT with bit_cnt=0 and the new word loaded, if a handshake occurs this edge (GAP_CYCLES=0 only);
    - GAP, if GAP_CYCLES>0;
    - IDLE, otherwise.
  - GAP: ser_valid=0, ser_out=IDLE_LEVEL, s_ready=0 for exactly GAP_CYCLES cycles, then IDLE.
- Latency:
  - A word accepted at edge k puts bit 0 of its sequence on ser_out during cycle k+1.
  - The last bit appears in cycle k+WIDTH.
  - With streaming, the next word's first bit follows in cycle k+WIDTH+1, with no bubble.
- Bit order:
  - MSB_FIRST=1: ser_out = s_data[WIDTH-1] first, down to s_data[0].
  - MSB_FIRST=0: s_data[0] first.
- ser_out, ser_valid, word_done and busy are registered with no combinational path from inputs. s_ready is the only combinational output.
- busy = (state != IDLE).
- bit_cnt width is clog2(WIDTH); it never exceeds WIDTH-1 and has no wrap beyond the word.
- Reset mid-word: the word in flight is dropped and not resumed. Outputs return to reset values immediately (asynchronously).
- s_valid dropping mid-word has no effect; the word completes.
- s_valid=0 at the last bit: next state is GAP or IDLE, and ser_valid falls the following cycle.
- Ideally the downstream detector keeps its pattern state across valid=0 cycles. It has no valid input, so idle cycles present IDLE_LEVEL bits to it. With IDLE_LEVEL=0, a gap can itself complete a "110" pattern after a word ending in "11"; the system integrator must account for this.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1, s_data=8'b1011_0110 accepted at edge k -> ser_out=1,0,1,1,0,1,1,0 in cycles k+1..k+8; ser_valid high exactly those 8 cycles; word_done only in k+8; then back to IDLE with s_ready=1.
- Streaming with GAP_CYCLES=0: words 8'hC3 then 8'h5A, s_valid held high -> 16 contiguous ser_valid cycles; second handshake at the edge ending cycle k+8; bits 11000011 01011010; two word_done pulses at k+8 and k+16.
- GAP_CYCLES=2, two words offered back-to-back -> two idle cycles at IDLE_LEVEL between words; s_ready low during the last bit and both gap cycles.
- MSB_FIRST=0, s_data=8'b0000_0011 -> ser_out=1,1,0,0,0,0,0,0; the detector downstream pulses detect on the third bit.
- Reset asserted asynchronously at bit 4 of a word -> ser_valid=0, ser_out=IDLE_LEVEL, busy=0 without waiting for clk; after release, s_ready=1 and no residual bits are emitted.
- s_data changed and s_valid dropped during SHIFT -> the emitted bits match only the word captured at the handshake; the word completes normally.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per clk, with optional idle gap and seamless streaming.
module bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned GW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;
    logic             busy_q, busy_d;

    logic             last_bit;
    logic             handshake;

    assign last_bit  = (bit_cnt_q == CW'(WIDTH - 1));

    // Ready in IDLE, or on the last bit when streaming without a gap.
    assign s_ready   = !reset && ((state_q == ST_IDLE) ||
                       ((state_q == ST_SHIFT) && last_bit && (GAP_CYCLES == 0)));
    assign handshake = s_valid && s_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            ser_out_q   <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        ser_out_d   = IDLE_LEVEL;
        ser_valid_d = 1'b0;
        word_done_d = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = s_data;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    if (handshake) begin
                        shreg_d   = s_data;
                        bit_cnt_d = '0;
                    end else if (GAP_CYCLES != 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else                                  gap_cnt_d = gap_cnt_q + GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // Output flops take the bit that the next cycle presents.
        ser_valid_d = (state_d == ST_SHIFT);
        if (ser_valid_d) ser_out_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        word_done_d = (state_d == ST_SHIFT) && (bit_cnt_d == CW'(WIDTH - 1));
        busy_d      = (state_d != ST_IDLE);
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: instance A (MSB first, no gap, idle 0)
// and instance B (LSB first, two-cycle gap, idle 1).
module tb_bit_serializer;

    localparam int unsigned W = 8;

    typedef struct {
        logic         vld;
        logic [W-1:0] data;
        logic         out;
        logic         sv;
        logic         wd;
        logic         bz;
        logic         rdy;
    } vec_t;

    logic         clk;
    logic         rst_a, rst_b;
    logic [W-1:0] sd_a, sd_b;
    logic         sv_a, sv_b;
    logic         rdy_a, so_a, vo_a, wd_a, bz_a;
    logic         rdy_b, so_b, vo_b, wd_b, bz_b;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t va[$];
    vec_t vb[$];

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset(rst_a), .s_data(sd_a), .s_valid(sv_a), .s_ready(rdy_a),
        .ser_out(so_a), .ser_valid(vo_a), .word_done(wd_a), .busy(bz_a)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .reset(rst_b), .s_data(sd_b), .s_valid(sv_b), .s_ready(rdy_b),
        .ser_out(so_b), .ser_valid(vo_b), .word_done(wd_b), .busy(bz_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int row, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b, expected %b", nm, row, act, exp);
        end
    endtask

    task automatic add(input bit to_b, input logic vld, input logic [W-1:0] d,
                       input logic o, input logic s, input logic w,
                       input logic b, input logic r);
        vec_t v;
        v.vld = vld; v.data = d; v.out = o; v.sv = s; v.wd = w; v.bz = b; v.rdy = r;
        if (to_b) vb.push_back(v);
        else      va.push_back(v);
    endtask

    // Row r: inputs driven during cycle r, outputs expected during cycle r.
    task automatic run_vecs(input bit sel);
        int   n;
        vec_t v;
        n = sel ? vb.size() : va.size();
        for (int r = 0; r < n; r++) begin
            v = sel ? vb[r] : va[r];
            @(negedge clk);
            if (sel) begin sv_b = v.vld; sd_b = v.data; end
            else     begin sv_a = v.vld; sd_a = v.data; end
            #1;
            if (sel) begin
                chk("b.ser_out", r, so_b, v.out);   chk("b.ser_valid", r, vo_b, v.sv);
                chk("b.word_done", r, wd_b, v.wd);  chk("b.busy", r, bz_b, v.bz);
                chk("b.s_ready", r, rdy_b, v.rdy);
            end else begin
                chk("a.ser_out", r, so_a, v.out);   chk("a.ser_valid", r, vo_a, v.sv);
                chk("a.word_done", r, wd_a, v.wd);  chk("a.busy", r, bz_a, v.bz);
                chk("a.s_ready", r, rdy_a, v.rdy);
            end
        end
    endtask

    initial begin
        logic [W-1:0] seq;

        // Instance A: single word B6, s_data scrambled and s_valid low during shift.
        add(0, 1, 8'hB6, 0, 0, 0, 0, 1);
        seq = 8'b1011_0110;
        for (int i = 0; i < 8; i++)
            add(0, 0, (i % 2 != 0) ? 8'hFF : 8'h00, seq[7-i], 1, i == 7, 1, i == 7);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1);
        // Streaming C3 then 5A with s_valid held high.
        add(0, 1, 8'hC3, 0, 0, 0, 0, 1);
        seq = 8'b1100_0011;
        for (int i = 0; i < 8; i++)
            add(0, 1, 8'h5A, seq[7-i], 1, i == 7, 1, i == 7);
        seq = 8'b0101_1010;
        for (int i = 0; i < 8; i++)
            add(0, 0, 8'hFF, seq[7-i], 1, i == 7, 1, i == 7);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1);

        // Instance B: 03 (LSB first -> 1100_0000), gap of 2, then 1E (-> 0111_1000).
        add(1, 1, 8'h03, 1, 0, 0, 0, 1);
        seq = 8'b1100_0000;
        for (int i = 0; i < 8; i++)
            add(1, 1, 8'h1E, seq[7-i], 1, i == 7, 1, 0);
        add(1, 1, 8'h1E, 1, 0, 0, 1, 0);
        add(1, 1, 8'h1E, 1, 0, 0, 1, 0);
        add(1, 1, 8'h1E, 1, 0, 0, 0, 1);
        seq = 8'b0111_1000;
        for (int i = 0; i < 8; i++)
            add(1, 0, 8'hFF, seq[7-i], 1, i == 7, 1, 0);
        add(1, 0, 8'h00, 1, 0, 0, 1, 0);
        add(1, 0, 8'h00, 1, 0, 0, 1, 0);
        add(1, 0, 8'h00, 1, 0, 0, 0, 1);

        rst_a = 1'b1; rst_b = 1'b1;
        sv_a = 1'b0;  sv_b = 1'b0;
        sd_a = '0;    sd_b = '0;
        #7;
        chk("rst.a.ser_out", 0, so_a, 1'b0);   chk("rst.a.ser_valid", 0, vo_a, 1'b0);
        chk("rst.a.word_done", 0, wd_a, 1'b0); chk("rst.a.busy", 0, bz_a, 1'b0);
        chk("rst.a.s_ready", 0, rdy_a, 1'b0);
        chk("rst.b.ser_out", 0, so_b, 1'b1);   chk("rst.b.ser_valid", 0, vo_b, 1'b0);
        chk("rst.b.s_ready", 0, rdy_b, 1'b0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        run_vecs(1'b0);
        run_vecs(1'b1);

        // Asynchronous reset during bit 4 of a word on instance A.
        @(negedge clk);
        sv_a = 1'b1; sd_a = 8'hFF;
        @(negedge clk);
        sv_a = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("arst.pre_valid", 0, vo_a, 1'b1);
        chk("arst.pre_out", 0, so_a, 1'b1);
        rst_a = 1'b1;
        #1;
        chk("arst.ser_valid", 0, vo_a, 1'b0);
        chk("arst.ser_out", 0, so_a, 1'b0);
        chk("arst.busy", 0, bz_a, 1'b0);
        chk("arst.word_done", 0, wd_a, 1'b0);
        chk("arst.s_ready", 0, rdy_a, 1'b0);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("arst.post_ready", 0, rdy_a, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("arst.no_residual_valid", i, vo_a, 1'b0);
            chk("arst.no_residual_out", i, so_a, 1'b0);
            chk("arst.idle_busy", i, bz_a, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
